// File: rtl/memory_pkg.sv
// Shared types for the memory subsystem: write-buffer FIFO entry, client
// source identifiers used by the arbiter, and the write-buffer FSM states.
package memory_pkg;

  typedef struct packed {
    logic [31:0] address;
    logic [15:0] wdata;
    logic [1:0]  wmask;
  } mem_write_entry_t;

  typedef enum logic [1:0] {
    SOURCE_NONE = 2'd0,
    SOURCE_USB  = 2'd1,
    SOURCE_SD   = 2'd2
  } e_source_request;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/mem_bus.sv
// Single-request memory bus: the controller holds request and fields until ack.
interface mem_bus;
  logic        request;
  logic        ack;
  logic        write;
  logic [31:0] address;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic [1:0]  wmask;

  modport memory (
    input  request, write, address, wdata, wmask,
    output ack, rdata
  );

  modport controller (
    output request, write, address, wdata, wmask,
    input  ack, rdata
  );
endinterface

// File: rtl/memory_write_fifo.sv
// Synchronous FIFO of posted-write entries. Push is dropped when full and pop
// is dropped when empty; push and pop in the same cycle leave count unchanged.
module memory_write_fifo
  import memory_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  mem_write_entry_t       push_data,
  input  logic                   pop,
  output mem_write_entry_t       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  mem_write_entry_t mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful between push and pop.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/memory_write_buffer.sv
// Posted-write buffer between a DMA client and its arbiter port. Writes are
// queued and acked at once; reads wait for the queue to drain so program
// order is preserved.
module memory_write_buffer
  import memory_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  mem_bus.memory     up_bus,
  mem_bus.controller down_bus,
  output logic       busy
);

  wb_state_e        state_q, state_d;
  logic             dn_req_q, dn_req_d;
  logic             dn_write_q, dn_write_d;
  logic [31:0]      dn_addr_q, dn_addr_d;
  logic [15:0]      dn_wdata_q, dn_wdata_d;
  logic [1:0]       dn_wmask_q, dn_wmask_d;
  logic             up_ack_q, up_ack_d;
  logic             guard_q, guard_d;
  logic [15:0]      rdata_q, rdata_d;

  logic             take_ok;
  logic             push;
  logic             pop;
  logic             rd_accept;
  mem_write_entry_t push_entry;
  mem_write_entry_t head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  memory_write_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign push_entry = '{address: up_bus.address, wdata: up_bus.wdata, wmask: up_bus.wmask};

  assign up_bus.ack       = up_ack_q;
  assign up_bus.rdata     = rdata_q;
  assign down_bus.request = dn_req_q;
  assign down_bus.write   = dn_write_q;
  assign down_bus.address = dn_addr_q;
  assign down_bus.wdata   = dn_wdata_q;
  assign down_bus.wmask   = dn_wmask_q;
  assign busy             = (fifo_count != '0) || dn_req_q || (state_q != ST_IDLE);

  // Upstream acceptance, ack guard and downstream FSM next-state.
  always_comb begin
    // A held request is blind for the ack cycle and the cycle after it.
    take_ok    = up_bus.request && !up_ack_q && !guard_q;
    push       = take_ok && up_bus.write && !fifo_full;
    rd_accept  = take_ok && !up_bus.write && fifo_empty && (state_q == ST_IDLE);

    state_d    = state_q;
    dn_req_d   = dn_req_q;
    dn_write_d = dn_write_q;
    dn_addr_d  = dn_addr_q;
    dn_wdata_d = dn_wdata_q;
    dn_wmask_d = dn_wmask_q;
    rdata_d    = rdata_q;
    pop        = 1'b0;
    up_ack_d   = push;
    guard_d    = up_ack_q;

    case (state_q)
      ST_IDLE: begin
        // Queued writes always go before a read.
        if (!fifo_empty) begin
          dn_req_d   = 1'b1;
          dn_write_d = 1'b1;
          dn_addr_d  = head.address;
          dn_wdata_d = head.wdata;
          dn_wmask_d = head.wmask;
          state_d    = ST_WRITE;
        end else if (rd_accept) begin
          dn_req_d   = 1'b1;
          dn_write_d = 1'b0;
          dn_addr_d  = up_bus.address;
          dn_wdata_d = up_bus.wdata;
          dn_wmask_d = up_bus.wmask;
          state_d    = ST_READ;
        end
      end
      ST_WRITE: begin
        if (down_bus.ack) begin
          pop      = 1'b1;
          dn_req_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_READ: begin
        if (down_bus.ack) begin
          rdata_d  = down_bus.rdata;
          dn_req_d = 1'b0;
          up_ack_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        dn_req_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Control registers; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      dn_req_q <= 1'b0;
      up_ack_q <= 1'b0;
      guard_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      dn_req_q <= dn_req_d;
      up_ack_q <= up_ack_d;
      guard_q  <= guard_d;
      rdata_q  <= rdata_d;
    end
  end

  // Downstream field registers; only qualified by request.
  always_ff @(posedge clk) begin
    dn_write_q <= dn_write_d;
    dn_addr_q  <= dn_addr_d;
    dn_wdata_q <= dn_wdata_d;
    dn_wmask_q <= dn_wmask_d;
  end

endmodule
